// File: rtl/calc_pkg.sv
// Shared key codes, ALU opcodes and sequencer states for the calculator front-end.
// Pure declarations and decode helpers; no timing or flow control of its own.
package calc_pkg;

    localparam logic [3:0] KEY_ADD    = 4'd10;
    localparam logic [3:0] KEY_SUB    = 4'd11;
    localparam logic [3:0] KEY_MUL    = 4'd12;
    localparam logic [3:0] KEY_DIV    = 4'd13;
    localparam logic [3:0] KEY_EQUALS = 4'd14;
    localparam logic [3:0] KEY_CLEAR  = 4'd15;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} alu_op_t;

    typedef enum logic [2:0] {ENTER_A, ENTER_B, ISSUE, WAIT, SHOW, ERROR} state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_oper(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    // Operator keys are contiguous, so the opcode is the offset from KEY_ADD.
    function automatic alu_op_t key_to_op(input logic [3:0] k);
        logic [3:0] d;
        d = k - KEY_ADD;
        return alu_op_t'(d[1:0]);
    endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Decimal digit append (value*10 + digit) with overflow flag; purely combinational,
// zero latency, no handshake.
module calc_digit_accum #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    // Four spare bits hold (2^WIDTH-1)*10+9 without wrapping.
    logic [WIDTH+3:0] wide;

    assign wide     = ({4'b0, value} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, digit};
    assign result   = wide[WIDTH-1:0];
    assign overflow = |wide[WIDTH+3:WIDTH];

endmodule

// File: rtl/calc_op_sequencer.sv
// Key-driven operand entry and ALU sequencing; one ISSUE cycle then WAIT until ack/timeout.
// Keys other than CLEAR are refused (key_ready=0) while a transaction is in flight.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic             alu_req,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic             alu_ack,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_error,
    output logic [WIDTH-1:0] display_value,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n, shown_q, shown_n;
    alu_op_t          op_q, op_n, next_op_q, next_op_n;
    logic             chain_q, chain_n, b_ent_q, b_ent_n, clr_q, clr_n;
    logic [CW-1:0]    cnt_q, cnt_n;

    logic             key_acc, k_clear, k_digit, k_oper, k_eq;
    logic [WIDTH-1:0] accum;
    logic             accum_ovf;

    calc_digit_accum #(.WIDTH(WIDTH)) u_accum (
        .value    ((state == ENTER_B) ? b_q : a_q),
        .digit    (key_code),
        .result   (accum),
        .overflow (accum_ovf)
    );

    assign busy      = (state == ISSUE) || (state == WAIT);
    assign key_ready = !busy;
    assign alu_req   = busy;
    assign err       = (state == ERROR);
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;

    assign key_acc = key_valid && (key_ready || (key_code == KEY_CLEAR));
    assign k_clear = key_acc && (key_code == KEY_CLEAR);
    assign k_digit = key_acc && is_digit(key_code);
    assign k_oper  = key_acc && is_oper(key_code);
    assign k_eq    = key_acc && (key_code == KEY_EQUALS);

    always_comb begin
        display_value = a_q;
        case (state)
            ENTER_B:     display_value = b_ent_q ? b_q : a_q;
            ISSUE, WAIT: display_value = shown_q;
            ERROR:       display_value = '1;
            default:     display_value = a_q;
        endcase
    end

    always_comb begin
        state_n   = state;
        a_n       = a_q;
        b_n       = b_q;
        op_n      = op_q;
        next_op_n = next_op_q;
        chain_n   = chain_q;
        b_ent_n   = b_ent_q;
        clr_n     = clr_q;
        cnt_n     = cnt_q;
        shown_n   = busy ? shown_q : display_value;

        if (k_clear) begin
            if (busy) begin
                clr_n = 1'b1;
            end else begin
                state_n = ENTER_A;
                a_n     = '0;
                b_n     = '0;
                op_n    = OP_ADD;
                b_ent_n = 1'b0;
                chain_n = 1'b0;
            end
        end

        case (state)
            ENTER_A: begin
                if (k_digit && !accum_ovf) a_n = accum;
                if (k_oper) begin
                    op_n    = key_to_op(key_code);
                    b_n     = '0;
                    b_ent_n = 1'b0;
                    state_n = ENTER_B;
                end
            end
            ENTER_B: begin
                if (k_digit && !accum_ovf) begin
                    b_n     = accum;
                    b_ent_n = 1'b1;
                end
                if (k_oper) begin
                    if (!b_ent_q) begin
                        op_n = key_to_op(key_code);
                    end else begin
                        next_op_n = key_to_op(key_code);
                        chain_n   = 1'b1;
                        state_n   = ISSUE;
                    end
                end
                if (k_eq && b_ent_q) begin
                    chain_n = 1'b0;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                cnt_n = cnt_q + CW'(1);
                if (alu_ack) begin
                    clr_n = 1'b0;
                    // A CLEAR arriving with the ack is honoured in the same cycle.
                    if (clr_q || k_clear) begin
                        state_n = ENTER_A;
                        a_n     = '0;
                        b_n     = '0;
                        op_n    = OP_ADD;
                        b_ent_n = 1'b0;
                        chain_n = 1'b0;
                    end else if (alu_error) begin
                        state_n = ERROR;
                    end else begin
                        a_n = alu_result;
                        if (chain_q) begin
                            op_n    = next_op_q;
                            b_n     = '0;
                            b_ent_n = 1'b0;
                            state_n = ENTER_B;
                        end else begin
                            state_n = SHOW;
                        end
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    clr_n   = 1'b0;
                    state_n = ERROR;
                end
            end
            SHOW: begin
                if (k_digit) begin
                    a_n     = WIDTH'(key_code);
                    state_n = ENTER_A;
                end
                if (k_oper) begin
                    op_n    = key_to_op(key_code);
                    b_n     = '0;
                    b_ent_n = 1'b0;
                    state_n = ENTER_B;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ENTER_A;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_ADD;
            next_op_q <= OP_ADD;
            chain_q   <= 1'b0;
            b_ent_q   <= 1'b0;
            clr_q     <= 1'b0;
            cnt_q     <= '0;
            shown_q   <= '0;
        end else begin
            a_q       <= a_n;
            b_q       <= b_n;
            op_q      <= op_n;
            next_op_q <= next_op_n;
            chain_q   <= chain_n;
            b_ent_q   <= b_ent_n;
            clr_q     <= clr_n;
            cnt_q     <= cnt_n;
            shown_q   <= shown_n;
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed key sequences with a scoreboard: ALU requests and status snapshots are queued
// as expectations and checked by an independent monitor on the falling clock edge.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       key_ready, alu_req, err, busy;
    logic [1:0] alu_op;
    logic [7:0] alu_a, alu_b, display_value;
    logic       alu_ack = 1'b0;
    logic [7:0] alu_result = 8'd0;
    logic       alu_error = 1'b0;

    calc_op_sequencer #(.WIDTH(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a),
        .alu_b(alu_b), .alu_ack(alu_ack), .alu_result(alu_result), .alu_error(alu_error),
        .display_value(display_value), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] len;
    } req_t;

    typedef struct packed {
        logic [7:0] disp;
        logic       err;
        logic       kr;
        logic       busy;
        logic       req;
        logic       chk_alu;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
    } st_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    req_t  req_q[$];
    st_t   st_q[$];
    string nm_q[$];
    logic  chk_stb = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: request operands on rising alu_req, request length on its fall, status on strobe.
    logic       req_prev = 1'b0;
    int         req_len  = 0;
    logic [7:0] len_exp  = 8'd0;
    always @(negedge clk) begin : mon
        req_t  e;
        st_t   s;
        st_t   g;
        string nm;
        if (alu_req && !req_prev) begin
            check("req_queued", 32'(req_q.size() != 0), 32'd1);
            if (req_q.size() != 0) begin
                e = req_q.pop_front();
                check("req_operands", 32'({alu_a, alu_b, alu_op}), 32'({e.a, e.b, e.op}));
                len_exp = e.len;
            end
            req_len = 1;
        end else if (alu_req) begin
            req_len++;
        end
        if (!alu_req && req_prev) check("req_length", 32'(req_len), 32'(len_exp));
        req_prev = alu_req;
        if (chk_stb) begin
            check("status_queued", 32'(st_q.size() != 0), 32'd1);
            if (st_q.size() != 0) begin
                s  = st_q.pop_front();
                nm = nm_q.pop_front();
                g  = s;
                g.disp = display_value;
                g.err  = err;
                g.kr   = key_ready;
                g.busy = busy;
                g.req  = alu_req;
                if (s.chk_alu) begin
                    g.a  = alu_a;
                    g.b  = alu_b;
                    g.op = alu_op;
                end
                check({"status_", nm}, 32'(g), 32'(s));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step();
        key_valid = 1'b0;
    endtask

    task automatic expect_st(input string nm, input logic [7:0] d, input logic e,
                             input logic kr, input logic b, input logic r, input logic alu0);
        st_q.push_back('{disp: d, err: e, kr: kr, busy: b, req: r, chk_alu: alu0,
                         a: 8'd0, b: 8'd0, op: 2'd0});
        nm_q.push_back(nm);
        chk_stb = 1'b1;
        step();
        chk_stb = 1'b0;
    endtask

    task automatic exp_req(input logic [7:0] a, input logic [7:0] b, input alu_op_t op,
                           input logic [7:0] len);
        req_q.push_back('{a: a, b: b, op: op, len: len});
    endtask

    task automatic do_ack(input int gap, input logic [7:0] res, input logic e);
        for (int i = 0; i < 20 && !alu_req; i++) step();
        check("wait_req", 32'(alu_req), 32'd1);
        repeat (gap) step();
        alu_ack    = 1'b1;
        alu_result = res;
        alu_error  = e;
        step();
        alu_ack   = 1'b0;
        alu_error = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        expect_st("in_reset", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        expect_st("after_reset", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // 12 + 3
        press(4'd1); press(4'd2); press(KEY_ADD); press(4'd3);
        expect_st("t1_entry_b", 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_req(8'd12, 8'd3, OP_ADD, 8'd2);
        press(KEY_EQUALS);
        expect_st("t1_issue_hold", 8'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_ack(0, 8'd15, 1'b0);
        expect_st("t1_show", 8'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        press(KEY_EQUALS);
        expect_st("t1_eq_ignored", 8'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        press(4'd7);
        expect_st("t1_show_digit", 8'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // 5 * 4 - 2 chained
        press(KEY_CLEAR);
        expect_st("t2_clear", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        press(4'd5); press(KEY_MUL); press(4'd4);
        exp_req(8'd5, 8'd4, OP_MUL, 8'd2);
        press(KEY_SUB);
        do_ack(1, 8'd20, 1'b0);
        expect_st("t2_chain", 8'd20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        press(4'd2);
        exp_req(8'd20, 8'd2, OP_SUB, 8'd2);
        press(KEY_EQUALS);
        do_ack(1, 8'd18, 1'b0);
        expect_st("t2_result", 8'd18, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // operator from SHOW keeps A, then replaced before any B digit
        press(KEY_ADD);
        expect_st("t2b_op_from_show", 8'd18, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        press(KEY_SUB); press(4'd2);
        expect_st("t2b_b_digit", 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_req(8'd18, 8'd2, OP_SUB, 8'd2);
        press(KEY_EQUALS);
        do_ack(1, 8'd16, 1'b0);
        expect_st("t2b_result", 8'd16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // digit overflow at 8 bits
        press(KEY_CLEAR);
        press(4'd2); press(4'd5); press(4'd6);
        expect_st("t3_256_rejected", 8'd25, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        press(4'd5);
        expect_st("t3_255", 8'd255, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        press(4'd0);
        expect_st("t3_2550_rejected", 8'd255, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // ALU error and recovery
        press(KEY_CLEAR);
        press(4'd9); press(KEY_DIV); press(4'd0);
        exp_req(8'd9, 8'd0, OP_DIV, 8'd2);
        press(KEY_EQUALS);
        do_ack(1, 8'd0, 1'b1);
        expect_st("t4_error", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        press(4'd3);
        expect_st("t4_digit_ignored", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        press(KEY_CLEAR);
        expect_st("t4_cleared", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // timeout: ISSUE plus 4 WAIT cycles, then late ack ignored
        press(4'd1); press(KEY_ADD); press(4'd1);
        exp_req(8'd1, 8'd1, OP_ADD, 8'd5);
        press(KEY_EQUALS);
        for (int i = 0; i < 20 && busy; i++) step();
        check("timeout_exit", 32'(busy), 32'd0);
        expect_st("t5_timeout_err", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        alu_ack    = 1'b1;
        alu_result = 8'd2;
        step();
        alu_ack = 1'b0;
        expect_st("t5_late_ack", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        press(KEY_CLEAR);

        // CLEAR pressed during the transaction
        press(4'd3); press(KEY_ADD); press(4'd4);
        exp_req(8'd3, 8'd4, OP_ADD, 8'd3);
        press(KEY_EQUALS);
        press(KEY_CLEAR);
        expect_st("t6_wait_held", 8'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_ack(0, 8'd7, 1'b0);
        expect_st("t6_cleared", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // CLEAR coincident with ack
        press(4'd3); press(KEY_ADD); press(4'd4);
        exp_req(8'd3, 8'd4, OP_ADD, 8'd2);
        press(KEY_EQUALS);
        step();
        key_valid = 1'b1; key_code = KEY_CLEAR; alu_ack = 1'b1; alu_result = 8'd7;
        step();
        key_valid = 1'b0; alu_ack = 1'b0;
        expect_st("t6_simul_clear", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // non-CLEAR key coincident with ack is dropped
        press(4'd3); press(KEY_ADD); press(4'd4);
        exp_req(8'd3, 8'd4, OP_ADD, 8'd2);
        press(KEY_EQUALS);
        step();
        key_valid = 1'b1; key_code = 4'd5; alu_ack = 1'b1; alu_result = 8'd7;
        step();
        key_valid = 1'b0; alu_ack = 1'b0;
        expect_st("t6_key_dropped", 8'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-WAIT
        press(KEY_CLEAR);
        press(4'd3); press(KEY_ADD); press(4'd4);
        exp_req(8'd3, 8'd4, OP_ADD, 8'd1);
        press(KEY_EQUALS);
        step();
        rst_n = 1'b0;
        #1;
        check("t7_req_drops_now", 32'(alu_req), 32'd0);
        expect_st("t7_in_reset", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        expect_st("t7_after_reset", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        repeat (3) step();
        check("req_queue_empty", 32'(req_q.size()), 32'd0);
        check("status_queue_empty", 32'(st_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Control front-end for the tiny_calculator arithmetic unit.
- Turns a stream of decoded key codes into operand entry, operator chaining and ALU transactions over a req/ack handshake.
- Holds the value to be displayed and the sticky error state.
- Sits between the keypad decoder (driven from ui_in) and the ALU datapath; owns all sequencing of the ALU.

Parameters:
- WIDTH, 8: operand/result width in bits; entered values are unsigned.
- TIMEOUT, 255: maximum cycles in WAIT before an ALU timeout error; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 EQUALS, 15 CLEAR
- key_ready  out  1  high when non-CLEAR keys are accepted
- alu_req  out  1  ALU request, held until ack
- alu_op  out  2  0 ADD, 1 SUB, 2 MUL, 3 DIV
- alu_a  out  WIDTH  operand A
- alu_b  out  WIDTH  operand B
- alu_ack  in  1  one-cycle completion strobe
- alu_result  in  WIDTH  valid when alu_ack=1
- alu_error  in  1  valid when alu_ack=1 (div-by-zero, overflow)
- display_value  out  WIDTH  value to show
- err  out  1  sticky error indicator
- busy  out  1  high in ISSUE/WAIT

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=ENTER_A; A=B=0; op=ADD; b_entered=0; clr_pending=0; timeout counter=0.
  - All outputs 0 except key_ready=1.
- key_ready=1 in ENTER_A, ENTER_B, SHOW and ERROR; 0 in ISSUE and WAIT.
- A key is accepted when key_valid=1 and (key_ready=1 or key_code=CLEAR).
- Digit entry: new = old*10 + digit, computed at WIDTH+4 bits. If new > 2^WIDTH-1, the digit is ignored and the value is unchanged. Digits in ERROR are ignored.
- ENTER_A:
  - Digit updates A.
  - Operator: op := key, B := 0, b_entered := 0, go to ENTER_B.
  - EQUALS: no effect.
- ENTER_B:
  - Digit updates B and sets b_entered.
  - Operator with b_entered=0: replaces op, stays in ENTER_B.
  - Operator with b_entered=1: issue the current op, save the new op as next_op, set chain=1.
  - EQUALS with b_entered=1: issue with chain=0.
  - EQUALS with b_entered=0: ignored.
- ISSUE (1 cycle, entered the cycle after the accepting key):
  - alu_req rises at the ISSUE clock edge.
  - alu_a/alu_b/alu_op hold A/B/op and stay stable while alu_req=1.
  - Then go to WAIT.
- WAIT:
  - alu_req stays high; the counter increments each cycle.
  - On alu_ack, alu_req drops on the next edge.
  - If clr_pending=1: discard the result and go to ENTER_A with reset values.
  - Else if alu_error=1: go to ERROR.
  - Else A := alu_result. If chain=1: op := next_op, B := 0, b_entered := 0, go to ENTER_B. If chain=0: go to SHOW.
  - If the counter reaches TIMEOUT without ack: drop alu_req, go to ERROR. A late ack arriving in any state other than WAIT is ignored.
- SHOW:
  - Digit: A := digit, go to ENTER_A.
  - Operator: A is kept; op := key, B := 0, go to ENTER_B.
  - EQUALS: ignored.
- ERROR:
  - err=1; display_value = all ones.
  - Only CLEAR exits, to ENTER_A with reset values.
- CLEAR:
  - In ENTER_A/ENTER_B/SHOW/ERROR: next cycle is the reset-value state, err=0.
  - In ISSUE/WAIT: set clr_pending; the transaction still completes per the handshake (alu_req is never dropped before ack or timeout).
- display_value:
  - A in ENTER_A/SHOW.
  - In ENTER_B: B if b_entered, else A.
  - In ISSUE/WAIT: the last shown value, held.
- busy = state in {ISSUE, WAIT}.
- Simultaneous key_valid and alu_ack in WAIT: the ack is processed. Only CLEAR is recorded (as clr_pending, honoured by the ack branch in the same cycle); any other key is dropped.

Decomposition:
- Package calc_pkg:
  - key code localparams (KEY_ADD..KEY_CLEAR);
  - 2-bit alu_op enum;
  - state enum {ENTER_A, ENTER_B, ISSUE, WAIT, SHOW, ERROR}.
- Sub-module calc_digit_accum: combinational value*10+digit with an overflow flag, WIDTH-parameterised, instantiated once and muxed onto A or B.

Test Plan:
- Keys 1,2,ADD,3,EQUALS; ack result=15 one cycle after req -> alu_a=12, alu_b=3, alu_op=0; display 15; state SHOW; alu_req high exactly until the cycle after ack.
- Keys 5,MUL,4,SUB,2,EQUALS -> first req a=5, b=4, op=MUL (ack 20); second req a=20, b=2, op=SUB (ack 18); display 18.
- WIDTH=8, keys 2,5,6 -> 256 rejected, display 25; then 5 -> display 255.
- 9,DIV,0,EQUALS; ack with alu_error=1 -> err=1, display 0xFF; digit ignored; CLEAR -> err=0, display 0, key_ready=1.
- TIMEOUT=4, no ack -> alu_req high exactly 4 cycles in WAIT, then err=1; a later ack has no effect.
- CLEAR during WAIT -> alu_req held; on ack, state ENTER_A, display 0. rst_n low mid-WAIT -> alu_req=0 immediately, all outputs at reset values.
